// File: rtl/jacaranda_mem_pkg.sv
// jacaranda_mem_pkg: bridge state encoding and default command bytes
package jacaranda_mem_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, LEN, WDATA, RDATA} state_t;
    localparam logic [7:0] DEF_CMD_WRITE = 8'h57;
    localparam logic [7:0] DEF_CMD_READ = 8'h52;
endpackage

// File: rtl/mem_bridge.sv
// mem_bridge: byte-stream command bridge (cmd, addr, len, data) to a sync-write/async-read memory
module mem_bridge
    import jacaranda_mem_pkg::*;
#(
    parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE,
    parameter logic [7:0] CMD_READ = DEF_CMD_READ
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_w_data,
    output logic       mem_w_en,
    input  logic [7:0] mem_r_data,
    output logic       busy,
    output logic       done,
    output logic       err
);
    state_t state;
    logic is_read;
    logic [8:0] count;
    logic rx_beat;
    assign rx_ready = state != RDATA;
    assign busy = state != IDLE;
    assign rx_beat = rx_valid && rx_ready;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            is_read <= 1'b0;
            count <= 9'd0;
            mem_addr <= 8'h00;
            mem_w_data <= 8'h00;
            mem_w_en <= 1'b0;
            tx_data <= 8'h00;
            tx_valid <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            mem_w_en <= 1'b0;
            // the address advances once the write pulse presenting it has completed
            if (mem_w_en)
                mem_addr <= mem_addr + 8'd1;
            case (state)
                IDLE: if (rx_beat) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        state <= ADDR;
                        is_read <= rx_data == CMD_READ;
                    end else
                        err <= 1'b1;
                end
                ADDR: if (rx_beat) begin
                    mem_addr <= rx_data;
                    state <= LEN;
                end
                LEN: if (rx_beat) begin
                    count <= {rx_data == 8'd0, rx_data};
                    state <= is_read ? RDATA : WDATA;
                end
                WDATA: if (rx_beat) begin
                    mem_w_data <= rx_data;
                    mem_w_en <= 1'b1;
                    count <= count - 9'd1;
                    if (count == 9'd1) begin
                        state <= IDLE;
                        done <= 1'b1;
                    end
                end
                RDATA: if (!tx_valid || tx_ready) begin
                    if (count != 9'd0) begin
                        tx_data <= mem_r_data;
                        tx_valid <= 1'b1;
                        mem_addr <= mem_addr + 8'd1;
                        count <= count - 9'd1;
                    end else if (tx_valid) begin
                        tx_valid <= 1'b0;
                        state <= IDLE;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: scoreboard bench; stimulus queues expected writes/reads, a negedge monitor checks them
module tb_mem_bridge;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic rx_ready;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready = 1'b0;
    logic [7:0] mem_addr, mem_w_data, mem_r_data;
    logic mem_w_en, busy, done, err;

    bit [7:0] mem [256];
    logic [15:0] wq [$];
    logic [7:0] rq [$];
    int checks = 0, passes = 0;
    int done_cnt = 0, err_cnt = 0, w_cnt = 0;
    logic stall_prev = 1'b0;
    logic [7:0] held = 8'h00;

    mem_bridge dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
        .mem_r_data(mem_r_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;
    assign mem_r_data = mem[mem_addr];
    always @(posedge clock) if (mem_w_en) mem[mem_addr] <= mem_w_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (mem_w_en) begin
            w_cnt++;
            if (wq.size() == 0) check("spurious_w_en", {mem_addr, mem_w_data}, 32'hFFFF_FFFF);
            else check("write", {mem_addr, mem_w_data}, wq.pop_front());
        end
        if (tx_valid && tx_ready) begin
            if (rq.size() == 0) check("spurious_tx", tx_data, 32'hFFFF_FFFF);
            else check("tx_byte", tx_data, rq.pop_front());
        end
        if (stall_prev && !reset) check("tx_hold", {tx_valid, tx_data}, {1'b1, held});
        stall_prev = tx_valid && !tx_ready;
        held = tx_data;
        done_cnt += done;
        err_cnt += err;
    end

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(posedge clock);
            #1 n++;
        end
        if (n >= 1000) check("idle_timeout", 1, 0);
        @(negedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        check(name, {mem_addr, mem_w_data, tx_data, mem_w_en, tx_valid, busy, done, err, rx_ready},
              {24'h0, 6'b000001});
    endtask

    initial begin
        int d0, e0, w0;
        repeat (2) @(posedge clock);
        #1 check_reset_state("reset_outputs");
        reset = 1'b0;
        @(posedge clock);
        #1;

        // write 57,10,03,AA,BB,CC back-to-back
        wq.push_back(16'h10AA); wq.push_back(16'h11BB); wq.push_back(16'h12CC);
        d0 = done_cnt;
        send(8'h57); send(8'h10); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
        check("done_with_last_we", {done, mem_w_en, busy, mem_addr}, {3'b110, 8'h12});
        @(posedge clock);
        #1 check("done_one_cycle", {done, mem_w_en, busy}, 3'b000);
        wait_idle();
        check("write3_done", done_cnt - d0, 1);
        check("write3_drained", wq.size(), 0);

        // read 52,10,02 with tx_ready stalled 3 cycles
        rq.push_back(8'hAA); rq.push_back(8'hBB);
        d0 = done_cnt; w0 = w_cnt;
        send(8'h52); send(8'h10); send(8'h02);
        repeat (3) @(posedge clock);
        #1 check("read_stalled", {tx_valid, tx_data, rx_ready}, {1'b1, 8'hAA, 1'b0});
        tx_ready = 1'b1;
        wait_idle();
        tx_ready = 1'b0;
        check("read_done", done_cnt - d0, 1);
        check("read_drained", rq.size(), 0);
        check("read_no_write", w_cnt - w0, 0);
        check("read_tx_cleared", tx_valid, 0);

        // wrap FE, FF, 00
        wq.push_back(16'hFE01); wq.push_back(16'hFF02); wq.push_back(16'h0003);
        d0 = done_cnt;
        send(8'h57); send(8'hFE); send(8'h03); send(8'h01); send(8'h02); send(8'h03);
        wait_idle();
        check("wrap_done", done_cnt - d0, 1);
        check("wrap_drained", wq.size(), 0);

        // length 0 means 256
        for (int i = 0; i < 256; i++) wq.push_back({i[7:0], i[7:0] ^ 8'h5A});
        d0 = done_cnt; w0 = w_cnt;
        send(8'h57); send(8'h00); send(8'h00);
        for (int i = 0; i < 256; i++) send(i[7:0] ^ 8'h5A);
        wait_idle();
        check("len256_count", w_cnt - w0, 256);
        check("len256_done", done_cnt - d0, 1);
        check("len256_drained", wq.size(), 0);

        // unrecognised command
        e0 = err_cnt;
        send(8'h41);
        check("err_pulse", {err, busy}, 2'b10);
        @(posedge clock);
        #1 check("err_one_cycle", {err, busy}, 2'b00);
        @(negedge clock);
        #1 check("err_count", err_cnt - e0, 1);

        // reset mid-write: 57,20,04,11,22 then reset
        wq.push_back(16'h2011); wq.push_back(16'h2122);
        w0 = w_cnt;
        send(8'h57); send(8'h20); send(8'h04); send(8'h11); send(8'h22);
        reset = 1'b1;
        @(posedge clock);
        #1 check_reset_state("abort_outputs");
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 check("abort_writes", w_cnt - w0, 2);
        check("abort_untouched", mem[8'h22], 8'h78);
        check("abort_idle", {busy, mem_w_en}, 2'b00);
        rq.push_back(8'h11); rq.push_back(8'h22);
        d0 = done_cnt;
        tx_ready = 1'b1;
        send(8'h52); send(8'h20); send(8'h02);
        wait_idle();
        tx_ready = 1'b0;
        check("post_reset_read_done", done_cnt - d0, 1);
        check("post_reset_read_drained", rq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
